// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Contents: fetch FSM state encoding, default FIFO depth (credit limit) and
// default instruction width.
package instr_fetch_stage_pkg;

  typedef enum logic [0:0] {
    StFetch = 1'b0,
    StDrain = 1'b1
  } fetch_state_e;

  localparam int unsigned DefaultFifoDepth = 2;
  localparam int unsigned DefaultIBits     = 32;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   push_i, data_i    write port (ignored when full or clearing)
//   pop_i, data_o     read port; data_o shows the head entry (ignored when empty)
//   clear_i           synchronous flush of all entries, wins over push/pop
//   full_o, empty_o   occupancy flags
//   count_o           number of entries held, 0..Depth
// Depth must be a power of two (pointers wrap naturally) and at least 2.
module fetch_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  input  logic                     clear_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
    count_o = count_q;
    data_o  = mem_q[rd_ptr_q];
    do_push = push_i && !full_o && !clear_i;
    do_pop  = pop_i && !empty_o && !clear_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: issues instruction-memory reads for the current PC,
// tells the PC apparatus when to advance, and hands {PC, instruction} pairs to
// decode in program order over a valid/ready handshake.
// Ports:
//   clk, reset                          clock, async active-high reset
//   pcIn, pcAdvance                     PC apparatus interface
//   flush                               redirect: kill all older work this cycle
//   imemReqValid/Ready/Addr             memory request channel
//   imemRespValid/Data                  in-order memory responses, <= 1 per cycle
//   instValid/Ready, instOut, instPcOut decode interface
//   fetchFault                          only with IFETCH_ALIGN_CHECK_EN: sticky
//                                       misaligned-PC flag, cleared by flush
// Optional feature macro: IFETCH_ALIGN_CHECK_EN.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned DBITS      = 32,
  parameter int unsigned IBITS      = DefaultIBits,
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] pcIn,
  output logic             pcAdvance,
  input  logic             flush,
  output logic             imemReqValid,
  input  logic             imemReqReady,
  output logic [DBITS-1:0] imemReqAddr,
  input  logic             imemRespValid,
  input  logic [IBITS-1:0] imemRespData,
  output logic             instValid,
  input  logic             instReady,
  output logic [IBITS-1:0] instOut,
  output logic [DBITS-1:0] instPcOut
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic             fetchFault
`endif
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned InUseW = CntW + 1;
  localparam int unsigned OutW   = DBITS + IBITS;

  fetch_state_e state_q, state_d;
  logic [CntW-1:0] discard_q, discard_d;

  // Requests in flight are exactly the entries of the PC tag queue.
  logic [CntW-1:0]   outstanding;
  logic              tag_full, tag_empty;
  logic [DBITS-1:0]  tag_pc;

  logic [CntW-1:0]   out_count;
  logic              out_full, out_empty;
  logic [OutW-1:0]   out_rdata;

  logic              misalign;
  logic              resp_vld, drop, issue_ok, issue, out_push, out_pop;
  logic [InUseW-1:0] in_use;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misalign = |pcIn[1:0];
`else
  assign misalign = 1'b0;
`endif

  // Output / datapath control.
  always_comb begin
    // A response with no tag to pair it with is ignored.
    resp_vld  = imemRespValid && !tag_empty;
    drop      = (discard_q != '0) || flush;
    out_push  = resp_vld && !drop && !out_full;
    instValid = !reset && !out_empty && !flush;
    out_pop   = instValid && instReady;
    // Credit counts the slot freed by a same-cycle pop so that a depth-2
    // queue sustains one instruction per cycle.
    in_use    = {1'b0, outstanding} + {1'b0, out_count} - InUseW'(out_pop);
    issue_ok  = !reset && (state_q == StFetch) && !flush && !misalign && !tag_full &&
                (in_use < InUseW'(FIFO_DEPTH));
    issue        = issue_ok && imemReqReady;
    imemReqValid = issue_ok;
    imemReqAddr  = pcIn;
    pcAdvance    = issue;
    instOut      = out_rdata[IBITS-1:0];
    instPcOut    = out_rdata[IBITS +: DBITS];
  end

  // Next-state: on flush every request still in flight after this cycle's
  // response must be thrown away; issue is gated by flush so none is added.
  always_comb begin
    discard_d = discard_q;
    if (flush) begin
      discard_d = outstanding - CntW'(resp_vld);
    end else if (resp_vld && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end

    state_d = state_q;
    unique case (state_q)
      StFetch: if (flush && (discard_d != '0)) state_d = StDrain;
      StDrain: if (discard_d == '0) state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (flush) begin
      fault_d = 1'b0;
    end else if ((state_q == StFetch) && misalign) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fetchFault = fault_q;
`endif

  fetch_fifo #(
    .Width (DBITS),
    .Depth (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (issue),
    .data_i  (pcIn),
    .pop_i   (resp_vld),
    .data_o  (tag_pc),
    .clear_i (1'b0),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (outstanding)
  );

  fetch_fifo #(
    .Width (OutW),
    .Depth (FIFO_DEPTH)
  ) u_out_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (out_push),
    .data_i  ({tag_pc, imemRespData}),
    .pop_i   (out_pop),
    .data_o  (out_rdata),
    .clear_i (flush),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

endmodule
